deal_scheduler: RTL and testbench

- Sequences card dealing between the game-control FSM and the card source.
- Queues the one-cycle card-load requests from the FSM and fetches each card from the card source over a req/ack handshake.
- Writes each card into the addressed hand-register slot.
- Tracks shoe depletion and forces a reshuffle handshake when the shoe is empty.

---
 rtl/deal_scheduler.sv | 140 ++++++++++++++
 tb/tb_deal_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deal_scheduler.sv
// Card-deal sequencer: queues hand-slot load requests, fetches cards over req/ack, forces reshuffles.
// Optional round statistics counters are built when ROUND_STATS_EN is defined.
module deal_scheduler #(
   parameter int FIFO_DEPTH = 4,
   parameter int SHOE_SIZE  = 52,
   parameter int CNT_W      = 8
) (
   input  logic             slow_clock,
   input  logic             resetb,
   input  logic [5:0]       load_req,
   output logic             card_req,
   input  logic             card_ack,
   input  logic [3:0]       card_in,
   output logic [5:0]       wr_en,
   output logic [3:0]       wr_card,
   output logic             deal_done,
   output logic             busy,
   output logic             shuffle_req,
   input  logic             shuffle_done,
   output logic [5:0]       cards_left,
   output logic             req_err,
   input  logic             round_end,
   input  logic             player_win_light,
   input  logic             dealer_win_light,
   output logic [CNT_W-1:0] p_wins,
   output logic [CNT_W-1:0] d_wins,
   output logic [CNT_W-1:0] ties
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int QW = PW + 1;

   typedef enum logic [1:0] {IDLE, REQ, WRITE, SHUFFLE} state_t;
   state_t state, nxt;

   logic [2:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [QW-1:0] count;
   logic [2:0]    push_slot, head;
   logic          push, pop, full, push_ok, multi, card_ok, ack_ok, card_bad;
   logic [3:0]    card_q;

   always_comb begin
      push_slot = 3'd0;
      for (int i = 5; i >= 0; i--)
         if (load_req[i]) push_slot = 3'(i);
   end

   assign push     = |load_req;
   assign multi    = (load_req & (load_req - 6'd1)) != 6'd0;
   assign pop      = (state == WRITE);
   assign full     = (count == QW'(FIFO_DEPTH));
   // a pop in the same cycle frees the slot, so a push into a full queue is still taken
   assign push_ok  = push && (!full || pop);
   assign head     = mem[rd_ptr];
   assign card_ok  = (card_in != 4'd0) && (card_in <= 4'd13);
   assign ack_ok   = (state == REQ) && card_req && card_ack && card_ok;
   assign card_bad = (state == REQ) && card_req && card_ack && !card_ok;

   always_ff @(posedge slow_clock)
      if (push_ok) mem[wr_ptr] <= push_slot;

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (count != '0) nxt = (cards_left == 6'd0) ? SHUFFLE : REQ;
         REQ:     if (ack_ok) nxt = WRITE;
         WRITE:   nxt = IDLE;
         SHUFFLE: if (shuffle_done) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // card_req is registered: it rises one cycle into REQ and drops for one cycle after any ack
   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         state      <= IDLE;
         card_req   <= 1'b0;
         card_q     <= 4'd0;
         cards_left <= 6'(SHOE_SIZE);
         req_err    <= 1'b0;
      end else begin
         state    <= nxt;
         card_req <= (state == REQ) && !(card_req && card_ack);
         if (ack_ok) card_q <= card_in;
         if (state == WRITE && cards_left != 6'd0)
            cards_left <= cards_left - 6'd1;
         else if (state == SHUFFLE && shuffle_done)
            cards_left <= 6'(SHOE_SIZE);
         if (multi || (push && full && !pop) || card_bad) req_err <= 1'b1;
      end
   end

   assign wr_en       = (state == WRITE) ? (6'b000001 << head) : 6'b000000;
   assign wr_card     = card_q;
   assign deal_done   = (state == WRITE);
   assign shuffle_req = (state == SHUFFLE);
   assign busy        = (state != IDLE) || (count != '0);

`ifdef ROUND_STATS_EN
   localparam logic [CNT_W-1:0] CMAX = '1;
   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         p_wins <= '0;
         d_wins <= '0;
         ties   <= '0;
      end else if (round_end) begin
         if (player_win_light && dealer_win_light) begin
            if (ties != CMAX) ties <= ties + 1'b1;
         end else if (player_win_light) begin
            if (p_wins != CMAX) p_wins <= p_wins + 1'b1;
         end else if (dealer_win_light) begin
            if (d_wins != CMAX) d_wins <= d_wins + 1'b1;
         end
      end
   end
`else
   logic unused_stats;
   assign unused_stats = &{1'b0, round_end, player_win_light, dealer_win_light};
   assign p_wins = '0;
   assign d_wins = '0;
   assign ties   = '0;
`endif

endmodule

// File: tb/tb_deal_scheduler.sv
// Bench for deal_scheduler: card-source model, write scoreboard, vector table plus corner sequences.
module tb_deal_scheduler;
   localparam int FD   = 4;
   localparam int SHOE = 52;
   localparam int CW   = 2;
`ifdef ROUND_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          slow_clock, resetb;
   logic [5:0]    load_req;
   logic          card_req, card_ack;
   logic [3:0]    card_in;
   logic [5:0]    wr_en;
   logic [3:0]    wr_card;
   logic          deal_done, busy, shuffle_req, shuffle_done;
   logic [5:0]    cards_left;
   logic          req_err, round_end, player_win_light, dealer_win_light;
   logic [CW-1:0] p_wins, d_wins, ties;

   deal_scheduler #(.FIFO_DEPTH(FD), .SHOE_SIZE(SHOE), .CNT_W(CW)) dut (
      .slow_clock(slow_clock), .resetb(resetb), .load_req(load_req),
      .card_req(card_req), .card_ack(card_ack), .card_in(card_in),
      .wr_en(wr_en), .wr_card(wr_card), .deal_done(deal_done), .busy(busy),
      .shuffle_req(shuffle_req), .shuffle_done(shuffle_done), .cards_left(cards_left),
      .req_err(req_err), .round_end(round_end), .player_win_light(player_win_light),
      .dealer_win_light(dealer_win_light), .p_wins(p_wins), .d_wins(d_wins), .ties(ties)
   );

   initial slow_clock = 1'b0;
   always #5 slow_clock = ~slow_clock;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   typedef struct { int slot; int card; } exp_t;
   exp_t sb[$];
   int   card_q[$];
   int   ack_delay = 0;
   bit   src_en = 1'b1;
   int   force_req = 0;
   int   force_done = 0;
   int   exp_left = SHOE;

   // Card source: acks a pending card_req after ack_delay cycles with the next queued card
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      card_ack = 1'b0;
      card_in  = 4'd0;
      forever begin
         @(negedge slow_clock);
         if (card_ack) begin
            card_ack = 1'b0;
            wait_cnt = 0;
         end else if (force_req != force_done) begin
            card_ack   = 1'b1;
            card_in    = 4'd5;
            force_done = force_req;
         end else if (card_req && src_en && card_q.size() > 0) begin
            if (wait_cnt >= ack_delay) begin
               card_ack = 1'b1;
               card_in  = 4'(card_q.pop_front());
               wait_cnt = 0;
            end else wait_cnt++;
         end else wait_cnt = 0;
      end
   end

   // Write monitor against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge slow_clock);
         if (wr_en != 6'd0 || deal_done) begin
            if (sb.size() == 0) chk("unexpected_write", int'(wr_en), 0);
            else begin
               e = sb.pop_front();
               chk("wr_en", int'(wr_en), 1 << e.slot);
               chk("wr_card", int'(wr_card), e.card);
               chk("deal_done", int'(deal_done), 1);
            end
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || sb.size() != 0) && n < 400) begin
         @(negedge slow_clock);
         n++;
      end
      chk("idle_timeout", int'(n < 400), 1);
   endtask

   task automatic push_req(input logic [5:0] lr, input int slot, input int card);
      load_req = lr;
      sb.push_back('{slot, card});
      card_q.push_back(card);
      exp_left--;
   endtask

   typedef struct { logic [5:0] load; int card; int slot; } vec_t;
   vec_t vecs[8];

   initial begin
      int n;
      vecs[0] = '{6'b000001,  5, 0};
      vecs[1] = '{6'b001000, 10, 3};
      vecs[2] = '{6'b000010,  1, 1};
      vecs[3] = '{6'b010000, 13, 4};
      vecs[4] = '{6'b100000,  2, 5};
      vecs[5] = '{6'b000100, 12, 2};
      vecs[6] = '{6'b001000,  6, 3};
      vecs[7] = '{6'b000001, 11, 0};

      resetb = 1'b0; load_req = '0; shuffle_done = 1'b0;
      round_end = 1'b0; player_win_light = 1'b0; dealer_win_light = 1'b0;
      repeat (2) @(negedge slow_clock);
      chk("rst_card_req", int'(card_req), 0);
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_deal_done", int'(deal_done), 0);
      chk("rst_shuffle_req", int'(shuffle_req), 0);
      chk("rst_req_err", int'(req_err), 0);
      chk("rst_wr_card", int'(wr_card), 0);
      chk("rst_cards_left", int'(cards_left), SHOE);
      chk("rst_busy", int'(busy), 0);
      chk("rst_stats", int'(p_wins) + int'(d_wins) + int'(ties), 0);
      resetb = 1'b1;
      @(negedge slow_clock);

      // single deal, ack two cycles late, with request latency
      ack_delay = 2;
      push_req(6'b000001, 0, 7);
      @(negedge slow_clock);
      load_req = '0;
      @(negedge slow_clock);
      chk("lat_card_req_n1", int'(card_req), 0);
      @(negedge slow_clock);
      chk("lat_card_req_n2", int'(card_req), 1);
      wait_idle();
      chk("t1_cards_left", int'(cards_left), 51);
      chk("t1_req_err", int'(req_err), 0);

      // vector table, four consecutive pulses per batch, immediate acks
      ack_delay = 0;
      for (int i = 0; i < 8; i++) begin
         push_req(vecs[i].load, vecs[i].slot, vecs[i].card);
         @(negedge slow_clock);
         if (i % 4 == 3) begin
            load_req = '0;
            wait_idle();
            chk("tbl_req_err", int'(req_err), 0);
            chk("tbl_cards_left", int'(cards_left), exp_left);
         end
      end

      // illegal card value then a good one
      ack_delay = 1;
      load_req = 6'b100000;
      sb.push_back('{5, 13});
      card_q.push_back(0);
      card_q.push_back(13);
      exp_left--;
      @(negedge slow_clock);
      load_req = '0;
      for (n = 0; n < 50; n++) begin
         @(posedge slow_clock);
         if (card_ack) break;
      end
      chk("bad_ack_seen", int'(n < 50), 1);
      @(negedge slow_clock);
      chk("bad_card_req_low", int'(card_req), 0);
      chk("bad_no_wr", int'(wr_en), 0);
      chk("bad_req_err", int'(req_err), 1);
      @(negedge slow_clock);
      chk("bad_card_req_again", int'(card_req), 1);
      wait_idle();
      chk("bad_cards_left", int'(cards_left), exp_left);

      // reset mid-handshake, then a stray ack
      src_en = 1'b0;
      load_req = 6'b001000;
      @(negedge slow_clock);
      load_req = '0;
      for (n = 0; n < 20 && !card_req; n++) @(negedge slow_clock);
      chk("rst_mid_card_req_seen", int'(card_req), 1);
      resetb = 1'b0;
      #1;
      chk("rst_mid_card_req", int'(card_req), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_req_err", int'(req_err), 0);
      chk("rst_mid_cards_left", int'(cards_left), SHOE);
      @(negedge slow_clock);
      resetb = 1'b1;
      exp_left = SHOE;
      src_en = 1'b1;
      force_req++;
      repeat (4) @(negedge slow_clock);
      chk("late_ack_busy", int'(busy), 0);
      chk("late_ack_cards_left", int'(cards_left), SHOE);

      // multi-bit request: lowest bit wins and flags an error
      push_req(6'b110100, 2, 4);
      @(negedge slow_clock);
      load_req = '0;
      chk("multi_req_err", int'(req_err), 1);
      wait_idle();
      chk("multi_cards_left", int'(cards_left), exp_left);

      // overflow: six pushes with acks held off
      resetb = 1'b0;
      @(negedge slow_clock);
      resetb = 1'b1;
      exp_left = SHOE;
      src_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) push_req(6'b1 << i, i, 2 * i + 2);
         else load_req = 6'b1 << i;
         @(negedge slow_clock);
         if (i == 3) chk("ovf_err_before", int'(req_err), 0);
         if (i == 4) chk("ovf_err_after", int'(req_err), 1);
      end
      load_req = '0;
      chk("ovf_busy", int'(busy), 1);
      src_en = 1'b1;
      wait_idle();
      chk("ovf_cards_left", int'(cards_left), 48);

      // drain the shoe to one card
      for (int i = 0; i < 47; i++) begin
         push_req(6'b1 << (i % 6), i % 6, (i % 13) + 1);
         @(negedge slow_clock);
         if (i % 4 == 3 || i == 46) begin
            load_req = '0;
            wait_idle();
         end
      end
      chk("shoe_one_left", int'(cards_left), 1);
      shuffle_done = 1'b1;
      @(negedge slow_clock);
      shuffle_done = 1'b0;
      chk("stray_shuffle_done", int'(cards_left), 1);
      chk("stray_shuffle_req", int'(shuffle_req), 0);

      push_req(6'b000001, 0, 3);
      @(negedge slow_clock);
      push_req(6'b000010, 1, 9);
      @(negedge slow_clock);
      load_req = '0;
      for (n = 0; n < 50 && !shuffle_req; n++) @(negedge slow_clock);
      chk("shuffle_req_seen", int'(shuffle_req), 1);
      chk("shuffle_cards_left", int'(cards_left), 0);
      chk("shuffle_no_card_req", int'(card_req), 0);
      repeat (5) @(negedge slow_clock);
      chk("shuffle_req_held", int'(shuffle_req), 1);
      shuffle_done = 1'b1;
      @(negedge slow_clock);
      shuffle_done = 1'b0;
      chk("shuffle_reload", int'(cards_left), SHOE);
      wait_idle();
      chk("shuffle_after_deal", int'(cards_left), SHOE - 1);

      // round statistics
      for (int i = 0; i < 8; i++) begin
         round_end = 1'b1;
         player_win_light = (i == 0 || i == 1 || i >= 4);
         dealer_win_light = (i == 0 || i == 2);
         @(negedge slow_clock);
         round_end = 1'b0;
         if (i == 3) begin
            chk("stats_ties", int'(ties), STATS ? 1 : 0);
            chk("stats_p_wins", int'(p_wins), STATS ? 1 : 0);
            chk("stats_d_wins", int'(d_wins), STATS ? 1 : 0);
         end
      end
      player_win_light = 1'b0;
      dealer_win_light = 1'b0;
      chk("stats_p_sat", int'(p_wins), STATS ? 3 : 0);
      chk("stats_ties_hold", int'(ties), STATS ? 1 : 0);
      chk("stats_d_hold", int'(d_wins), STATS ? 1 : 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
